// File: rtl/fpu_pkg.sv
// Shared FP16 format definitions for the FPU operand path and its consumers.
package fpu_pkg;

  localparam int EXP_W  = 5;
  localparam int FRAC_W = 10;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp16_t;

  localparam logic [15:0]      FP16_QNAN = 16'h7E00;
  localparam logic [EXP_W-1:0] EXP_ONES  = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } redState_t;

endpackage

// File: rtl/fpu_classify.sv
// Combinational class flags for one FP value: NaN, Inf, zero and sign.
module fpu_classify
  import fpu_pkg::*;
#(
  parameter type FP_T = fp16_t
) (
  input  logic [$bits(FP_T)-1:0] x,
  output logic                   isNaN,
  output logic                   isInf,
  output logic                   isZero,
  output logic                   isNeg
);

  FP_T v;

  assign v      = FP_T'(x);
  assign isNaN  = (v.exp == EXP_ONES) && (v.frac != '0);
  assign isInf  = (v.exp == EXP_ONES) && (v.frac == '0);
  assign isZero = (v.exp == '0) && (v.frac == '0);
  assign isNeg  = v.sign;

endmodule

// File: rtl/fpu_cmp.sv
// Strict less-than on two non-NaN FP values split into sign, magnitude and class flags.
module fpu_cmp #(
  parameter int MAG_W = 15
) (
  input  logic [MAG_W-1:0] aMag,
  input  logic             aNeg,
  input  logic             aInf,
  input  logic             aZero,
  input  logic [MAG_W-1:0] bMag,
  input  logic             bNeg,
  input  logic             bInf,
  input  logic             bZero,
  output logic             lt
);

  logic magLt;
  logic magGt;

  assign magLt = aMag < bMag;
  assign magGt = aMag > bMag;

  always_comb begin
    lt = 1'b0;
    if (aZero && bZero) begin
      // signed zeros are distinct: -0 sorts below +0
      lt = aNeg && !bNeg;
    end else if (aNeg != bNeg) begin
      lt = aNeg;
    end else if (aInf || bInf) begin
      lt = aNeg ? (aInf && !bInf) : (bInf && !aInf);
    end else begin
      lt = aNeg ? magGt : magLt;
    end
  end

endmodule

// File: rtl/fpu_minmax_reduce.sv
// Streaming FP min/max reduction: one element per cycle in, one result beat per packet out.
module fpu_minmax_reduce
  import fpu_pkg::*;
#(
  parameter type FP_T  = fp16_t,
  parameter int  IDX_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    inValid,
  output logic                    inReady,
  input  logic [$bits(FP_T)-1:0]  inData,
  input  logic                    inLast,
  output logic                    outValid,
  input  logic                    outReady,
  output logic [$bits(FP_T)-1:0]  outMin,
  output logic [$bits(FP_T)-1:0]  outMax,
  output logic [IDX_W-1:0]        outMinIdx,
  output logic [IDX_W-1:0]        outMaxIdx,
  output logic [IDX_W-1:0]        outCount,
  output logic                    outNaN,
  output logic                    outSat
);

  localparam int W = $bits(FP_T);
  localparam logic [W-1:0] QNAN = W'(FP16_QNAN);

  redState_t        state, nState;
  logic [W-1:0]     minV, maxV, nMin, nMax;
  logic [IDX_W-1:0] minIdx, maxIdx, count, nMinIdx, nMaxIdx, nCount;
  logic             minInf, maxInf, minZero, maxZero;
  logic             nMinInf, nMaxInf, nMinZero, nMaxZero;
  logic             nanSeen, sat, nNaN, nSat;
  logic             xNaN, xInf, xZero, xNeg;
  logic             ltMin, gtMax;
  logic             accept, loadOut, anyValid;

  assign inReady  = (state != DONE);
  assign outValid = (state == DONE);
  assign accept   = inValid && inReady;
  assign loadOut  = accept && inLast;

  fpu_classify #(.FP_T(FP_T)) uClass (
    .x      (inData),
    .isNaN  (xNaN),
    .isInf  (xInf),
    .isZero (xZero),
    .isNeg  (xNeg)
  );

  fpu_cmp #(.MAG_W(W-1)) uCmpMin (
    .aMag  (inData[W-2:0]),
    .aNeg  (xNeg),
    .aInf  (xInf),
    .aZero (xZero),
    .bMag  (minV[W-2:0]),
    .bNeg  (minV[W-1]),
    .bInf  (minInf),
    .bZero (minZero),
    .lt    (ltMin)
  );

  // max comparison is the same relation with operands swapped: max < x
  fpu_cmp #(.MAG_W(W-1)) uCmpMax (
    .aMag  (maxV[W-2:0]),
    .aNeg  (maxV[W-1]),
    .aInf  (maxInf),
    .aZero (maxZero),
    .bMag  (inData[W-2:0]),
    .bNeg  (xNeg),
    .bInf  (xInf),
    .bZero (xZero),
    .lt    (gtMax)
  );

  always_comb begin
    nState   = state;
    nMin     = minV;
    nMax     = maxV;
    nMinIdx  = minIdx;
    nMaxIdx  = maxIdx;
    nMinInf  = minInf;
    nMaxInf  = maxInf;
    nMinZero = minZero;
    nMaxZero = maxZero;
    nCount   = count;
    nNaN     = nanSeen;
    nSat     = sat;
    case (state)
      IDLE, ACCUM: begin
        if (accept) begin
          // index of this beat is the pre-increment count, which clamps with it
          nCount = (count == '1) ? count : count + 1'b1;
          nSat   = sat || (count == '1);
          if (xNaN) begin
            nNaN = 1'b1;
          end else if (state == IDLE) begin
            nMin     = inData;
            nMax     = inData;
            nMinIdx  = count;
            nMaxIdx  = count;
            nMinInf  = xInf;
            nMaxInf  = xInf;
            nMinZero = xZero;
            nMaxZero = xZero;
            nState   = ACCUM;
          end else begin
            if (ltMin) begin
              nMin     = inData;
              nMinIdx  = count;
              nMinInf  = xInf;
              nMinZero = xZero;
            end
            if (gtMax) begin
              nMax     = inData;
              nMaxIdx  = count;
              nMaxInf  = xInf;
              nMaxZero = xZero;
            end
          end
          if (inLast) begin
            nState = DONE;
          end
        end
      end
      DONE: begin
        if (outReady) begin
          nMin     = '0;
          nMax     = '0;
          nMinIdx  = '0;
          nMaxIdx  = '0;
          nMinInf  = 1'b0;
          nMaxInf  = 1'b0;
          nMinZero = 1'b0;
          nMaxZero = 1'b0;
          nCount   = '0;
          nNaN     = 1'b0;
          nSat     = 1'b0;
          nState   = IDLE;
        end
      end
      default: nState = IDLE;
    endcase
  end

  // an all-NaN packet never leaves IDLE and never loads an extremum
  assign anyValid = (state == ACCUM) || !xNaN;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      minV    <= '0;
      maxV    <= '0;
      minIdx  <= '0;
      maxIdx  <= '0;
      minInf  <= 1'b0;
      maxInf  <= 1'b0;
      minZero <= 1'b0;
      maxZero <= 1'b0;
      count   <= '0;
      nanSeen <= 1'b0;
      sat     <= 1'b0;
    end else begin
      state   <= nState;
      minV    <= nMin;
      maxV    <= nMax;
      minIdx  <= nMinIdx;
      maxIdx  <= nMaxIdx;
      minInf  <= nMinInf;
      maxInf  <= nMaxInf;
      minZero <= nMinZero;
      maxZero <= nMaxZero;
      count   <= nCount;
      nanSeen <= nNaN;
      sat     <= nSat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outMin    <= '0;
      outMax    <= '0;
      outMinIdx <= '0;
      outMaxIdx <= '0;
      outCount  <= '0;
      outNaN    <= 1'b0;
      outSat    <= 1'b0;
    end else if (loadOut) begin
      outMin    <= anyValid ? nMin : QNAN;
      outMax    <= anyValid ? nMax : QNAN;
      outMinIdx <= anyValid ? nMinIdx : '0;
      outMaxIdx <= anyValid ? nMaxIdx : '0;
      outCount  <= nCount;
      outNaN    <= nNaN;
      outSat    <= nSat;
    end
  end

endmodule

// File: tb/tb_fpu_minmax_reduce.sv
// Directed scoreboard bench for fpu_minmax_reduce (full-width and 2-bit-index instances).
module tb_fpu_minmax_reduce;
  import fpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inValid = 1'b0;
  logic        inLast = 1'b0;
  logic        outReady = 1'b0;
  logic [15:0] inData = '0;

  logic        inReady, outValid, outNaN, outSat;
  logic [15:0] outMin, outMax, outMinIdx, outMaxIdx, outCount;
  logic        sInReady, sOutValid, sOutNaN, sOutSat;
  logic [15:0] sOutMin, sOutMax;
  logic [1:0]  sOutMinIdx, sOutMaxIdx, sOutCount;

  always #5 clk = ~clk;

  fpu_minmax_reduce dut (
    .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady),
    .inData(inData), .inLast(inLast), .outValid(outValid), .outReady(outReady),
    .outMin(outMin), .outMax(outMax), .outMinIdx(outMinIdx), .outMaxIdx(outMaxIdx),
    .outCount(outCount), .outNaN(outNaN), .outSat(outSat)
  );

  fpu_minmax_reduce #(.IDX_W(2)) dutS (
    .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(sInReady),
    .inData(inData), .inLast(inLast), .outValid(sOutValid), .outReady(outReady),
    .outMin(sOutMin), .outMax(sOutMax), .outMinIdx(sOutMinIdx), .outMaxIdx(sOutMaxIdx),
    .outCount(sOutCount), .outNaN(sOutNaN), .outSat(sOutSat)
  );

  typedef struct {
    logic [15:0] mn, mx, mnI, mxI, cnt;
    logic        nan, sat;
    bit          chkS;
    logic [1:0]  sMnI, sMxI, sCnt;
    logic        sSat;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [15:0] mn, input logic [15:0] mx, input logic [15:0] mnI,
                      input logic [15:0] mxI, input logic [15:0] cnt, input logic nan);
    exp_t e;
    e = '{mn: mn, mx: mx, mnI: mnI, mxI: mxI, cnt: cnt, nan: nan, sat: 1'b0,
          chkS: 1'b0, sMnI: 2'd0, sMxI: 2'd0, sCnt: 2'd0, sSat: 1'b0};
    sb.push_back(e);
  endtask

  task automatic beat(input logic [15:0] d, input logic last);
    int n = 0;
    @(negedge clk);
    while (!inReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!inReady) begin
      check("inReadyTimeout", {31'd0, inReady}, 32'd1);
    end else begin
      inValid = 1'b1;
      inData  = d;
      inLast  = last;
      @(posedge clk);
      #1;
      inValid = 1'b0;
      inLast  = 1'b0;
    end
  endtask

  task automatic collect(input bit ack);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    check("latency", {31'd0, outValid}, 32'd1);
    while (!outValid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() == 0) begin
      check("scoreboardEmpty", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check("inReadyInDone", {31'd0, inReady}, 32'd0);
      check("outMin", {16'd0, outMin}, {16'd0, e.mn});
      check("outMax", {16'd0, outMax}, {16'd0, e.mx});
      check("outMinIdx", {16'd0, outMinIdx}, {16'd0, e.mnI});
      check("outMaxIdx", {16'd0, outMaxIdx}, {16'd0, e.mxI});
      check("outCount", {16'd0, outCount}, {16'd0, e.cnt});
      check("outNaN", {31'd0, outNaN}, {31'd0, e.nan});
      check("outSat", {31'd0, outSat}, {31'd0, e.sat});
      if (e.chkS) begin
        check("sOutMin", {16'd0, sOutMin}, {16'd0, e.mn});
        check("sOutMax", {16'd0, sOutMax}, {16'd0, e.mx});
        check("sOutMinIdx", {30'd0, sOutMinIdx}, {30'd0, e.sMnI});
        check("sOutMaxIdx", {30'd0, sOutMaxIdx}, {30'd0, e.sMxI});
        check("sOutCount", {30'd0, sOutCount}, {30'd0, e.sCnt});
        check("sOutSat", {31'd0, sOutSat}, {31'd0, e.sSat});
      end
    end
    if (ack) begin
      outReady = 1'b1;
      @(posedge clk);
      #1;
      outReady = 1'b0;
    end
  endtask

  initial begin
    exp_t es;

    // reset state
    repeat (2) @(negedge clk);
    check("rstInReady", {31'd0, inReady}, 32'd1);
    check("rstOutValid", {31'd0, outValid}, 32'd0);
    check("rstOutMin", {16'd0, outMin}, 32'd0);
    check("rstOutMax", {16'd0, outMax}, 32'd0);
    check("rstIdx", {outMinIdx, outMaxIdx}, 32'd0);
    check("rstCount", {16'd0, outCount}, 32'd0);
    check("rstFlags", {30'd0, outNaN, outSat}, 32'd0);
    rst_n = 1'b1;

    // mixed finite values
    push(16'hBC00, 16'h4000, 16'd2, 16'd1, 16'd4, 1'b0);
    beat(16'h3C00, 1'b0); beat(16'h4000, 1'b0); beat(16'hBC00, 1'b0); beat(16'h3800, 1'b1);
    collect(1'b1);

    // leading NaN, infinities
    push(16'hFC00, 16'h7C00, 16'd1, 16'd2, 16'd4, 1'b1);
    beat(16'h7E00, 1'b0); beat(16'hFC00, 1'b0); beat(16'h7C00, 1'b0); beat(16'h4200, 1'b1);
    collect(1'b1);

    // all-NaN packet, last on a NaN beat
    push(16'h7E00, 16'h7E00, 16'd0, 16'd0, 16'd2, 1'b1);
    beat(16'h7E00, 1'b0); beat(16'h7E00, 1'b1);
    collect(1'b1);

    // signed zeros and a max tie
    push(16'h8000, 16'h4000, 16'd2, 16'd0, 16'd4, 1'b0);
    beat(16'h4000, 1'b0); beat(16'h0000, 1'b0); beat(16'h8000, 1'b0); beat(16'h4000, 1'b1);
    collect(1'b1);

    // backpressure: hold the result for 5 cycles
    push(16'h3C00, 16'h4200, 16'd1, 16'd0, 16'd2, 1'b0);
    beat(16'h4200, 1'b0); beat(16'h3C00, 1'b1);
    collect(1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("holdValid", {31'd0, outValid}, 32'd1);
      check("holdInReady", {31'd0, inReady}, 32'd0);
      check("holdOutMin", {16'd0, outMin}, 32'h3C00);
      check("holdOutMax", {16'd0, outMax}, 32'h4200);
    end
    outReady = 1'b1;
    @(posedge clk);
    #1;
    outReady = 1'b0;
    @(negedge clk);
    check("releaseInReady", {31'd0, inReady}, 32'd1);
    check("releaseOutValid", {31'd0, outValid}, 32'd0);

    // single-beat packet
    push(16'h3C00, 16'h3C00, 16'd0, 16'd0, 16'd1, 1'b0);
    beat(16'h3C00, 1'b1);
    collect(1'b1);

    // reset in the middle of a packet
    beat(16'h5000, 1'b0); beat(16'hD000, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midRstOutValid", {31'd0, outValid}, 32'd0);
    check("midRstInReady", {31'd0, inReady}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    push(16'h4200, 16'h4200, 16'd0, 16'd0, 16'd1, 1'b0);
    beat(16'h4200, 1'b1);
    collect(1'b1);

    // count saturation on the 2-bit index instance
    es = '{mn: 16'hBC00, mx: 16'h4400, mnI: 16'd2, mxI: 16'd4, cnt: 16'd5, nan: 1'b0, sat: 1'b0,
           chkS: 1'b1, sMnI: 2'd2, sMxI: 2'd3, sCnt: 2'd3, sSat: 1'b1};
    sb.push_back(es);
    beat(16'h3C00, 1'b0); beat(16'h4000, 1'b0); beat(16'hBC00, 1'b0);
    beat(16'h3800, 1'b0); beat(16'h4400, 1'b1);
    collect(1'b1);

    check("scoreboardDrained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fpu_minmax_reduce.md
# fpu_minmax_reduce

Streaming floating-point min/max reduction unit. Accepts a packet of FP values on a valid/ready stream, one per cycle, and tracks the running minimum and maximum with their first-occurrence indices. Returns one result beat per packet on a valid/ready output stream. It sits downstream of the FPU operand path and is the consumer of the FP ordering relation (lt/gt) and the Inf/NaN classification flags.

## Interface
- FP_T, default fp16_t: packed {sign, exp, frac} FP format.
- IDX_W, default 16: width of the index and count fields.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- inValid  input  1  input beat valid.
- inReady  output  1  block can accept an input beat.
- inData  input  $bits(FP_T)  element value.
- inLast  input  1  final element of the packet.
- outValid  output  1  result valid.
- outReady  input  1  downstream accepts the result.
- outMin, outMax  output  $bits(FP_T)  packet minimum and maximum.
- outMinIdx, outMaxIdx  output  IDX_W  zero-based index of the first occurrence of each.
- outCount  output  IDX_W  number of elements accepted, saturating.
- outNaN  output  1  at least one NaN element was seen.
- outSat  output  1  count saturated; indices are unreliable.

## Operation
- Input transfer happens when inValid && inReady. Output transfer happens when outValid && outReady.
- FSM states:
  - IDLE: no valid element held yet.
  - ACCUM: at least one non-NaN extremum held.
  - DONE: result presented.
- inReady = (state != DONE). outValid = (state == DONE).
- **Per accepted element x at position i (i = count before increment):**
  - NaN (exp all ones, frac != 0): sets nanSeen. Min/max are unchanged. Count increments.
  - Non-NaN, first one in the packet: min = max = x, minIdx = maxIdx = i.
  - Otherwise: min/idx update only if x < min strictly; max/idx update only if x > max strictly. Ties keep the earliest index.
- **Ordering:**
  - -Inf is less than every finite value, which is less than +Inf.
  - Same-sign values order by {exp, frac} magnitude, inverted for negatives.
  - A negative value is less than a positive value. This includes -0 < +0.
  - Subnormals need no special handling.
- **All-NaN packet:** outMin = outMax = the canonical qNaN (FP16_QNAN = 16'h7E00), both indices 0, outNaN = 1.
- **Count:** increments per accepted beat and saturates at 2^IDX_W-1. On saturation, outSat is set. Indices for positions at or beyond saturation are recorded as 2^IDX_W-1.
- **inLast transition:** accepting a beat with inLast moves the FSM to DONE and registers the outputs.
- **DONE exit:** on output transfer, all accumulators clear and the FSM returns to IDLE.
- A single-element packet (first beat has inLast) is legal.
- inLast on a NaN beat is legal.
- Reset mid-packet discards all partial state. No result is emitted for that packet.

## Timing
- Reset values: state IDLE, inReady 1, outValid 0, all result outputs 0, outNaN 0, outSat 0.
- Throughput is 1 element/cycle while in IDLE or ACCUM.
- Latency: a last beat accepted on edge t gives outValid = 1 with stable outputs from just after edge t.
- Outputs hold constant while outValid && !outReady.
- inReady is 0 for every cycle in DONE. It returns to 1 the cycle after the output transfer, so there is one bubble per packet.
- No combinational path from inValid or outReady to any output other than the FSM-derived inReady/outValid registers.

## Structure
- **Shared package fpu_pkg:**
  - fp16_t typedef.
  - FP16_QNAN constant.
  - EXP_ONES exponent constant.
- **Sub-module fpu_classify (combinational):**
  - Input: one FP_T.
  - Outputs: isNaN, isInf, isZero.
  - The reduction instantiates it once on inData.
- Ordering comparisons (x vs min, x vs max) are two parallel instances of the team's standard FP comparator block. isInf/isNaN come from fpu_classify and from registered flags for min/max.

## Test plan
- Packet [0x3C00, 0x4000, 0xBC00, 0x3800(last)] -> one beat later: outMin 0xBC00 idx 2, outMax 0x4000 idx 1, count 4, outNaN 0.
- Packet [0x7E00, 0xFC00, 0x7C00, 0x4200(last)] -> outMin 0xFC00 idx 1, outMax 0x7C00 idx 2, count 4, outNaN 1.
- Packet [0x7E00, 0x7E00(last)] -> outMin = outMax = 0x7E00, indices 0, count 2, outNaN 1.
- Packet [0x4000, 0x0000, 0x8000, 0x4000(last)] -> outMin 0x8000 idx 2, outMax 0x4000 idx 0 (tie keeps first).
- Hold outReady = 0 for 5 cycles after result -> outputs stable, inReady 0 throughout. Release -> inReady 1 next cycle. A following single-beat packet [0x3C00(last)] yields min = max = 0x3C00, count 1.
- Assert rst_n low after 2 beats of a packet -> outValid 0, inReady 1. A new packet [0x4200(last)] gives count 1 with no leakage of old data. With IDX_W = 2, a 5-beat packet gives count 3 and outSat 1.
